// File: rtl/multi_channel_edge_detector.sv
// ---------------------------------------------------------------------------
// MultiChannelEdgeDetector
//
// Conditions a bank of independent asynchronous input lines so the
// interrupt/status logic of a peripheral can use them. Each channel passes
// through four stages in order:
//   1. a shift-register synchroniser,
//   2. a debounce filter that only accepts a level after it has been stable
//      for FILTER_CYCLES synchronised cycles,
//   3. rising / falling / any edge detection on the filtered level,
//   4. sticky pending flags that capture the mode-selected edges until they
//      are cleared.
//
// Parameters:
//   WIDTH         number of independent channels (1..32)
//   SYNC_STAGES   synchroniser flip-flops per channel (>= 2)
//   FILTER_CYCLES cycles a new level must hold before acceptance (>= 1)
//   RESET_LEVEL   level loaded into synchroniser/filter/previous flops (0/1)
//
// Ports:
//   clock        system clock
//   reset        asynchronous reset, active low
//   dataIn       raw asynchronous channel inputs
//   mode         per-channel capture mode, bits [2i+1:2i]:
//                00 off, 01 rising, 10 falling, 11 both
//   clear        per-channel pending clear, sampled on clock
//   filteredOut  debounced level per channel
//   risingEdge   one-cycle pulse when the filtered level goes 0->1
//   fallingEdge  one-cycle pulse when the filtered level goes 1->0
//   anyEdge      risingEdge | fallingEdge
//   pending      sticky flags of mode-selected edges
//   interrupt    OR of all pending bits
// ---------------------------------------------------------------------------
module multi_channel_edge_detector #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int RESET_LEVEL   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     dataIn,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clear,
    output logic [WIDTH-1:0]     filteredOut,
    output logic [WIDTH-1:0]     risingEdge,
    output logic [WIDTH-1:0]     fallingEdge,
    output logic [WIDTH-1:0]     anyEdge,
    output logic [WIDTH-1:0]     pending,
    output logic                 interrupt
);

    // One extra counter bit keeps FILTER_CYCLES = 1 legal (a 1-bit counter
    // that simply never leaves 0).
    localparam int COUNT_WIDTH = $clog2(FILTER_CYCLES) + 1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(FILTER_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_WORD = (RESET_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0]       syncChain [SYNC_STAGES];
    logic [WIDTH-1:0]       syncOut;
    logic [COUNT_WIDTH-1:0] filterCount [WIDTH];
    logic [WIDTH-1:0]       filtered;
    logic [WIDTH-1:0]       previousFiltered;
    logic [WIDTH-1:0]       captureSet;
    logic [WIDTH-1:0]       pendingReg;

    // Synchroniser: a plain shift chain per channel. Nothing may sit between
    // stages, otherwise the metastability settling time is eaten by logic.
    // Reset loads RESET_LEVEL so an input idling at that level does not look
    // like a change once reset is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                syncChain[s] <= RESET_WORD;
            end
        end else begin
            syncChain[0] <= dataIn;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                syncChain[s] <= syncChain[s-1];
            end
        end
    end

    assign syncOut = syncChain[SYNC_STAGES-1];

    // Debounce filter: the counter measures how long the synchronised level
    // has disagreed with the accepted level. Any return to agreement restarts
    // it from zero, so only an uninterrupted run of FILTER_CYCLES differing
    // samples moves the filtered level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filtered <= RESET_WORD;
            for (int ch = 0; ch < WIDTH; ch++) begin
                filterCount[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                if (syncOut[ch] == filtered[ch]) begin
                    filterCount[ch] <= '0;
                end else if (filterCount[ch] == COUNT_LAST) begin
                    filtered[ch]    <= syncOut[ch];
                    filterCount[ch] <= '0;
                end else begin
                    filterCount[ch] <= filterCount[ch] + COUNT_ONE;
                end
            end
        end
    end

    // Previous filtered level, one cycle behind, so that edges show up as a
    // single-cycle difference between the two registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            previousFiltered <= RESET_WORD;
        end else begin
            previousFiltered <= filtered;
        end
    end

    // Edge pulses come straight from registers, so they are glitch-free and
    // last exactly one cycle.
    assign filteredOut = filtered;
    assign risingEdge  = filtered & ~previousFiltered;
    assign fallingEdge = ~filtered & previousFiltered;
    assign anyEdge     = filtered ^ previousFiltered;

    // Select which edges each channel captures: mode bit 2i enables rising,
    // bit 2i+1 enables falling. Mode 00 blocks capture but leaves the edge
    // pulses and filtered level untouched.
    always_comb begin
        captureSet = '0;
        for (int ch = 0; ch < WIDTH; ch++) begin
            captureSet[ch] = (mode[2*ch] & risingEdge[ch]) | (mode[2*ch+1] & fallingEdge[ch]);
        end
    end

    // Sticky pending flags. A new capture is OR-ed in after the clear mask,
    // so an edge arriving in the same cycle as a clear is never lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pendingReg <= '0;
        end else begin
            pendingReg <= captureSet | (pendingReg & ~clear);
        end
    end

    assign pending   = pendingReg;
    assign interrupt = |pendingReg;

endmodule

// File: doc/multi_channel_edge_detector.md
Name: multi_channel_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit synchronous edge detector.
- Per channel, in order:
  - synchronises an asynchronous input,
  - debounces it with a stability counter,
  - detects rising, falling and any edges on the filtered level,
  - latches selected edges into sticky pending flags with clear-by-pulse.
- Sits between external pins (buttons, sensor lines, UART-like status lines) and the interrupt/status logic of a peripheral.

Parameters:
- WIDTH, 8, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2).
- FILTER_CYCLES, 4, consecutive cycles a new synchronised level must hold before it is accepted (>=1; 1 = no debounce).
- RESET_LEVEL, 0, level loaded into all synchroniser, filter and previous-level flops at reset (0 or 1).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- dataIn  input  WIDTH  raw asynchronous channel inputs
- mode  input  2*WIDTH  per-channel capture mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clear  input  WIDTH  per-channel pending clear, sampled on clock
- filteredOut  output  WIDTH  debounced level per channel
- risingEdge  output  WIDTH  1-cycle pulse, filtered level went 0->1
- fallingEdge  output  WIDTH  1-cycle pulse, filtered level went 1->0
- anyEdge  output  WIDTH  risingEdge | fallingEdge
- pending  output  WIDTH  sticky flags of mode-selected edges
- interrupt  output  1  OR of all pending bits

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - synchroniser chains, filtered level and previous filtered level all become RESET_LEVEL;
  - filter counters 0; pending 0.
  - Hence risingEdge/fallingEdge/anyEdge = 0, interrupt = 0, filteredOut = {WIDTH{RESET_LEVEL}}.
  - Release of reset produces no spurious edge if dataIn equals RESET_LEVEL.
- Reset mid-operation: all state, including counters mid-count and pending flags, is discarded immediately.
- Synchroniser: per channel a SYNC_STAGES-deep shift chain; syncOut = last stage. No logic between stages.
- Filter, per channel, counter width $clog2(FILTER_CYCLES)+1:
  - syncOut == filtered: counter <= 0.
  - syncOut != filtered and counter == FILTER_CYCLES-1: filtered <= syncOut, counter <= 0.
  - else: counter <= counter+1.
  - A glitch shorter than FILTER_CYCLES synchronised cycles never reaches filtered; the counter restarts from 0 on every reversal.
- Edge detection is combinational on registered state. previousFiltered <= filtered each clock.
  - risingEdge = filtered & ~previousFiltered
  - fallingEdge = ~filtered & previousFiltered
  - anyEdge = filtered ^ previousFiltered
- Latency for a clean change of dataIn set up before clock edge 0:
  - filtered updates at edge SYNC_STAGES+FILTER_CYCLES-1;
  - the edge pulse is high for exactly the following cycle;
  - pending sets at edge SYNC_STAGES+FILTER_CYCLES.
- Pending, per channel, on each clock:
  - set = (mode[2i] & risingEdge[i]) | (mode[2i+1] & fallingEdge[i]);
  - pending <= set | (pending & ~clear).
  - Set and clear in the same cycle: set wins, pending stays 1.
  - Clear with no pending: no effect.
- Mode changes affect only edges occurring after the change; existing pending bits are kept. Mode 00 blocks capture, but edge pulses and filteredOut still operate.
- interrupt = |pending, combinational from registers, glitch-free.
- Channels are fully independent; simultaneous edges on several channels are all captured in the same cycle.

Test Plan:
- Reset, RESET_LEVEL=0: hold reset=0 with dataIn=8'h00, release.
  - All outputs 0.
  - Then dataIn[0]=1 at edge 0 (defaults): filteredOut[0]=1 after edge 5; risingEdge[0] high for one cycle only; pending[0]=1 and interrupt=1 after edge 6.
- Glitch rejection: dataIn[3] high for 3 cycles, then low (FILTER_CYCLES=4).
  - No edge pulse, filteredOut[3] stays 0, pending stays 8'h00.
  - Same stimulus held 4 cycles: exactly one rising pulse.
- Mode masking: mode channel 2 = 10.
  - Rising edge on channel 2: risingEdge[2] pulses, pending[2] stays 0.
  - Subsequent falling edge: pending[2]=1.
  - Mode 00: no capture on either edge.
- Clear collision: with pending[5]=1, pulse clear[5] in the same cycle a new selected edge on channel 5 sets. Required: pending[5] stays 1.
  - A second clear pulse alone gives pending[5]=0 and interrupt=0.
- Asynchronous reset mid-debounce: reset=0 asserted between clock edges while a channel counter is 2 and pending=8'hA5.
  - pending=0 and interrupt=0 before the next clock edge.
  - After release no edge reported with dataIn=8'h00.
- Multi-channel, WIDTH=32, FILTER_CYCLES=1, SYNC_STAGES=3, RESET_LEVEL=1: all inputs toggle 1->0 together with mode=all 11.
  - fallingEdge=32'hFFFFFFFF for one cycle after edge 3.
  - pending=32'hFFFFFFFF after edge 4.
